// File: rtl/puf_trng_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | puf_trng_pkg: shared types and helpers for the arbiter-PUF TRNG    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package puf_trng_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        RUN  = 2'd2,
        FAIL = 2'd3
    } state_t;

    localparam int C_LE       = 128;
    localparam int C_OUT_W    = 32;
    localparam int C_TAP_A    = 127;
    localparam int C_TAP_B    = 125;
    localparam int C_TAP_C    = 100;
    localparam int C_TAP_D    = 98;
    localparam int C_MAX_MISS = 16;

    // XNOR feedback keeps the all-zero state live; all-ones is the lock-up state.
    function automatic logic xnor_fb(input logic a, input logic b, input logic c, input logic d);
        return ~(a ^ b ^ c ^ d);
    endfunction

endpackage
`default_nettype wire

// File: rtl/chal_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | chal_lfsr: challenge shift register, seeded serially or fed by PUF |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module chal_lfsr
    import puf_trng_pkg::*;
#(
    parameter int LE    = C_LE,
    parameter int TAP_A = C_TAP_A,
    parameter int TAP_B = C_TAP_B,
    parameter int TAP_C = C_TAP_C,
    parameter int TAP_D = C_TAP_D
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          shift,
    input  logic          seed_sel,
    input  logic          guard,
    input  logic          seed_bit,
    input  logic          puf_bit,
    input  logic          agree,
    output logic [LE-1:0] chal
);

    logic          w_new_bit;
    logic [LE-1:0] w_next;

    always_comb begin
        w_new_bit = 1'b0;
        if (seed_sel) begin
            w_new_bit = seed_bit;
        end else if (agree) begin
            w_new_bit = puf_bit;
        end else begin
            w_new_bit = xnor_fb(chal[TAP_A], chal[TAP_B], chal[TAP_C], chal[TAP_D]);
        end
        w_next = {chal[LE-2:0], w_new_bit};
        // An all-ones seed would pin the XNOR feedback forever.
        if (guard && (&w_next)) begin
            w_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chal <= '0;
        end else if (shift) begin
            chal <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/puf_trng_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | puf_trng_ctrl: arbiter-PUF TRNG controller (seed, collect, health) |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module puf_trng_ctrl
    import puf_trng_pkg::*;
#(
    parameter int LE       = C_LE,
    parameter int OUT_W    = C_OUT_W,
    parameter int TAP_A    = C_TAP_A,
    parameter int TAP_B    = C_TAP_B,
    parameter int TAP_C    = C_TAP_C,
    parameter int TAP_D    = C_TAP_D,
    parameter int MAX_MISS = C_MAX_MISS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic             seed_bit,
    output logic [LE-1:0]    chal,
    input  logic             puf_q1,
    input  logic             puf_q2,
    output logic [OUT_W-1:0] rnd_data,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             busy,
    output logic             running,
    output logic             health_fail,
    output logic             overrun
);

    localparam int c_SEED_W = $clog2(LE);
    localparam int c_BIT_W  = $clog2(OUT_W + 1);
    localparam int c_MISS_W = $clog2(MAX_MISS + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_SEED_W-1:0]   r_seed_cnt;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic [c_MISS_W-1:0]   r_miss_cnt;
    logic [OUT_W-1:0]      r_acc;
    logic [OUT_W-1:0]      r_data;
    logic                  r_valid;
    logic                  r_overrun;

    logic w_agree;
    logic w_seed_shift;
    logic w_run_shift;
    logic w_seed_last;
    logic w_full;
    logic w_xfer;
    logic w_blocked;
    logic w_collect;
    logic w_miss_trip;

    assign w_agree      = ~(puf_q1 ^ puf_q2);
    assign w_seed_shift = (r_state == SEED) && en && !start;
    assign w_run_shift  = (r_state == RUN) && en && !start;
    assign w_seed_last  = (r_seed_cnt == c_SEED_W'(LE - 1));
    assign w_full       = (r_bit_cnt == c_BIT_W'(OUT_W));
    assign w_xfer       = (r_state == RUN) && !start && w_full && (!r_valid || rnd_ready);
    assign w_blocked    = w_full && !w_xfer;
    assign w_collect    = w_run_shift && w_agree && !w_blocked;
    assign w_miss_trip  = w_run_shift && !w_agree && (r_miss_cnt == c_MISS_W'(MAX_MISS - 1));

    chal_lfsr #(
        .LE    (LE),
        .TAP_A (TAP_A),
        .TAP_B (TAP_B),
        .TAP_C (TAP_C),
        .TAP_D (TAP_D)
    ) u_chal_lfsr (
        .clk      (clock),
        .rst      (reset),
        .shift    (w_seed_shift || w_run_shift),
        .seed_sel (r_state == SEED),
        .guard    (w_seed_shift && w_seed_last),
        .seed_bit (seed_bit),
        .puf_bit  (puf_q2),
        .agree    (w_agree),
        .chal     (chal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = SEED;
        end else begin
            case (r_state)
                SEED:    if (w_seed_shift && w_seed_last) w_state_nxt = RUN;
                RUN:     if (w_miss_trip) w_state_nxt = FAIL;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_seed_cnt <= '0;
            r_bit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_acc      <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (start) begin
            r_seed_cnt <= '0;
            r_bit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_acc      <= '0;
            r_valid    <= 1'b0;
        end else begin
            if (w_seed_shift) begin
                r_seed_cnt <= w_seed_last ? '0 : r_seed_cnt + c_SEED_W'(1);
            end
            if (w_run_shift) begin
                r_miss_cnt <= w_agree ? '0 : r_miss_cnt + c_MISS_W'(1);
            end

            if (w_xfer) begin
                r_data    <= r_acc;
                r_valid   <= 1'b1;
                r_bit_cnt <= w_collect ? c_BIT_W'(1) : '0;
            end else if (r_valid && rnd_ready) begin
                r_valid <= 1'b0;
            end

            if (w_collect) begin
                r_acc <= {r_acc[OUT_W-2:0], puf_q1};
                if (!w_xfer) begin
                    r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                end
            end

            if (w_run_shift && w_agree && w_blocked) begin
                r_overrun <= 1'b1;
            end

            // Health failure invalidates anything collected from this challenge stream.
            if (w_state_nxt == FAIL) begin
                r_valid   <= 1'b0;
                r_acc     <= '0;
                r_bit_cnt <= '0;
            end
        end
    end

    assign rnd_data    = r_data;
    assign rnd_valid   = r_valid;
    assign overrun     = r_overrun;
    assign busy        = (r_state == SEED);
    assign running     = (r_state == RUN);
    assign health_fail = (r_state == FAIL);

endmodule
`default_nettype wire

// File: tb/tb_puf_trng_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_puf_trng_ctrl: scoreboard bench for the PUF TRNG controller     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_puf_trng_ctrl;

    localparam int LE    = 128;
    localparam int OUT_W = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic             en;
    logic             start;
    logic             seed_bit;
    logic [LE-1:0]    chal;
    logic             puf_q1;
    logic             puf_q2;
    logic [OUT_W-1:0] rnd_data;
    logic             rnd_valid;
    logic             rnd_ready;
    logic             busy;
    logic             running;
    logic             health_fail;
    logic             overrun;

    int n_checks = 0;
    int n_errors = 0;

    logic [OUT_W-1:0] exp_q[$];
    logic [LE-1:0]    m_chal;

    always #5 clock = ~clock;

    puf_trng_ctrl u_dut (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .start       (start),
        .seed_bit    (seed_bit),
        .chal        (chal),
        .puf_q1      (puf_q1),
        .puf_q2      (puf_q2),
        .rnd_data    (rnd_data),
        .rnd_valid   (rnd_valid),
        .rnd_ready   (rnd_ready),
        .busy        (busy),
        .running     (running),
        .health_fail (health_fail),
        .overrun     (overrun)
    );

    task automatic check(input string tag, input logic [LE-1:0] got, input logic [LE-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word consumed at the coming edge: compare against the scoreboard.
    always @(negedge clock) begin
        if (!reset && rnd_valid && rnd_ready) begin
            check("sb_pending", LE'(exp_q.size() > 0), LE'(1));
            if (exp_q.size() > 0) begin
                check("sb_word", rnd_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_tick();
        en = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic seed_word(input logic [LE-1:0] v);
        for (int i = 0; i < LE; i++) begin
            en       = 1'b1;
            seed_bit = v[LE-1-i];
            tick();
            m_chal = {m_chal[LE-2:0], v[LE-1-i]};
        end
        if (&m_chal) m_chal[0] = 1'b0;
        en = 1'b0;
    endtask

    task automatic run_bit(input logic q1, input logic q2);
        logic fb;
        en     = 1'b1;
        puf_q1 = q1;
        puf_q2 = q2;
        fb     = ~(m_chal[127] ^ m_chal[125] ^ m_chal[100] ^ m_chal[98]);
        tick();
        m_chal = {m_chal[LE-2:0], (q1 == q2) ? q2 : fb};
    endtask

    task automatic run_word(input logic [OUT_W-1:0] w);
        for (int i = 0; i < OUT_W; i++) begin
            run_bit(w[OUT_W-1-i], w[OUT_W-1-i]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_chal"}, chal, '0);
        check({tag, "_data"}, rnd_data, '0);
        check({tag, "_valid"}, rnd_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_running"}, running, 0);
        check({tag, "_health"}, health_fail, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        logic [OUT_W-1:0] w1, w2, w3, w4, w5, w6;
        reset = 1'b1; en = 1'b0; start = 1'b0; seed_bit = 1'b0;
        puf_q1 = 1'b0; puf_q2 = 1'b0; rnd_ready = 1'b0; m_chal = '0;
        w1 = $urandom; w2 = $urandom; w3 = $urandom;
        w4 = $urandom; w5 = $urandom; w6 = $urandom;

        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;

        // Alternating seed 1,0,... -> 0xAAAA...
        pulse_start();
        check("start_busy", busy, 1);
        seed_word({64{2'b10}});
        check("seed_chal", chal, {64{2'b10}});
        check("seed_busy_fall", busy, 0);
        check("seed_running", running, 1);

        // Fully agreeing PUF, consumer always ready
        rnd_ready = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        run_word(32'hDEADBEEF);
        check("word_not_yet", rnd_valid, 0);
        idle_tick();
        check("word_valid_rise", rnd_valid, 1);
        check("run_chal", chal, {{48{2'b10}}, 32'hDEADBEEF});
        idle_tick();
        check("word_valid_fall", rnd_valid, 0);

        // en=0 mid-word freezes chal and bit count
        exp_q.push_back(w3);
        for (int i = 0; i < 16; i++) run_bit(w3[31-i], w3[31-i]);
        repeat (10) begin
            en = 1'b0; puf_q1 = 1'($urandom); puf_q2 = ~puf_q1;
            tick();
        end
        check("freeze_chal", chal, m_chal);
        for (int i = 16; i < 32; i++) run_bit(w3[31-i], w3[31-i]);
        idle_tick();
        check("freeze_word_valid", rnd_valid, 1);
        idle_tick();

        // Backpressure: two words fill output and accumulator, then overflow
        rnd_ready = 1'b0;
        exp_q.push_back(w1);
        exp_q.push_back(w2);
        run_word(w1);
        run_word(w2);
        check("bp_data_held", rnd_data, w1);
        check("bp_valid", rnd_valid, 1);
        check("bp_no_overrun", overrun, 0);
        run_bit(~w2[0], ~w2[0]);
        check("bp_overrun", overrun, 1);
        en = 1'b0;
        rnd_ready = 1'b1;
        tick();
        check("bp_second_valid", rnd_valid, 1);
        check("bp_second_data", rnd_data, w2);
        tick();
        check("bp_drained", rnd_valid, 0);

        // start in RUN with a pending word
        rnd_ready = 1'b0;
        run_word(w4);
        idle_tick();
        check("pend_valid", rnd_valid, 1);
        pulse_start();
        check("restart_valid_clr", rnd_valid, 0);
        check("restart_busy", busy, 1);
        check("restart_data_held", rnd_data, w4);

        // Disagreement on an all-zero challenge
        seed_word('0);
        check("zero_seed_chal", chal, '0);
        rnd_ready = 1'b1;
        for (int i = 0; i < 3; i++) run_bit(1'b1, 1'b0);
        check("disagree_chal", chal, 128'd7);
        check("disagree_no_word", rnd_valid, 0);
        exp_q.push_back(w5);
        run_word(w5);
        idle_tick();
        check("after_miss_valid", rnd_valid, 1);
        idle_tick();

        // Health test
        rnd_ready = 1'b0;
        run_word(w6);
        idle_tick();
        check("pre_fail_valid", rnd_valid, 1);
        for (int i = 0; i < 15; i++) run_bit(1'b0, 1'b1);
        check("miss15_health", health_fail, 0);
        check("miss15_running", running, 1);
        run_bit(1'b0, 1'b1);
        check("miss16_health", health_fail, 1);
        check("miss16_valid", rnd_valid, 0);
        check("miss16_running", running, 0);
        check("miss16_chal", chal, m_chal);
        repeat (4) begin
            en = 1'b1; puf_q1 = 1'b1; puf_q2 = 1'b0;
            tick();
        end
        check("fail_chal_frozen", chal, m_chal);
        pulse_start();
        check("fail_restart_busy", busy, 1);
        check("fail_restart_health", health_fail, 0);

        // All-ones seed gets the lock-up guard
        seed_word('1);
        check("ones_guard_chal", chal, {{(LE-1){1'b1}}, 1'b0});
        check("ones_running", running, 1);

        // Reset in the middle of seeding
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            en = 1'b1; seed_bit = 1'b1;
            tick();
        end
        reset = 1'b1;
        en = 1'b0;
        tick();
        check_all_zero("midseed_reset");
        reset = 1'b0;
        tick();

        check("sb_drained", LE'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
